// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline front end: NOP encoding, default reset
// vector and the fetch-address legality check.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-aligned and inside a memory of 'words' 32-bit words.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
        logic [33:0] limit;
        limit = {2'b00, words} << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a synchronous-read instruction memory, tags the
// returned word with its PC, absorbs decode stalls, takes redirects, traps bad PCs.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_addr
);

    logic [31:0] f_pc;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic        hold;

    // A bubble never needs holding, so a stall only bites when a real word is present.
    assign hold = id_stall && r_valid;

    // Re-presenting r_pc on a hold makes the memory return the same word again.
    always_comb begin
        imem_addr = f_pc;
        if (fault_q) begin
            imem_addr = r_pc;
        end else if (redirect_valid) begin
            imem_addr = redirect_target;
        end else if (hold) begin
            imem_addr = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc         <= RESET_PC;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else if (!fault_q) begin
            if (redirect_valid) begin
                if (addr_legal(redirect_target, MEM_WORDS)) begin
                    r_pc    <= redirect_target;
                    r_valid <= 1'b1;
                    f_pc    <= redirect_target + 32'd4;
                end else begin
                    fault_q      <= 1'b1;
                    fault_addr_q <= redirect_target;
                    r_valid      <= 1'b0;
                end
            end else if (!hold) begin
                if (addr_legal(f_pc, MEM_WORDS)) begin
                    r_pc    <= f_pc;
                    r_valid <= 1'b1;
                    f_pc    <= f_pc + 32'd4;
                end else begin
                    fault_q      <= 1'b1;
                    fault_addr_q <= f_pc;
                    r_valid      <= 1'b0;
                end
            end
        end
    end

    assign if_valid    = r_valid && !fault_q;
    assign if_instr    = if_valid ? imem_rdata : NOP_INSTR;
    assign if_pc       = r_pc;
    assign if_pc_plus4 = r_pc + 32'd4;
    assign fetch_fault = fault_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset vector 0 and 0xF8) sharing
// one synchronous-read memory image; expectations are hand-computed per cycle.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];

    // Instance at the default reset vector.
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_instr, if_pc, if_pc_plus4, fault_addr;
    logic        if_valid, fetch_fault;

    // Instance starting near the top of memory.
    logic        reset_hi;
    logic [31:0] imem_addr_hi, imem_rdata_hi;
    logic        id_stall_hi, redirect_valid_hi;
    logic [31:0] redirect_target_hi;
    logic [31:0] if_instr_hi, if_pc_hi, if_pc_plus4_hi, fault_addr_hi;
    logic        if_valid_hi, fetch_fault_hi;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(64)) u_dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
        .fetch_fault(fetch_fault), .fault_addr(fault_addr)
    );

    fetch_unit #(.RESET_PC(32'h0000_00F8), .MEM_WORDS(64)) u_dut_hi (
        .clk(clk), .reset(reset_hi),
        .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
        .id_stall(id_stall_hi), .redirect_valid(redirect_valid_hi), .redirect_target(redirect_target_hi),
        .if_instr(if_instr_hi), .if_pc(if_pc_hi), .if_pc_plus4(if_pc_plus4_hi), .if_valid(if_valid_hi),
        .fetch_fault(fetch_fault_hi), .fault_addr(fault_addr_hi)
    );

    always @(posedge clk) begin
        imem_rdata    <= mem[imem_addr[7:2]];
        imem_rdata_hi <= mem[imem_addr_hi[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h3408_0006;
        mem[1] = 32'hAC08_0000;

        reset = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        reset_hi = 1'b1; id_stall_hi = 1'b0; redirect_valid_hi = 1'b0; redirect_target_hi = 32'h0;

        next_cycle();
        sample_point();
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);
        next_cycle();
        reset = 1'b0;

        // Cycle 1: address edge for PC 0, no data yet
        sample_point();
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", {31'b0, if_valid}, 32'h0);
        check("c1_instr", if_instr, 32'h0);

        // Cycle 2: first instruction
        next_cycle();
        sample_point();
        check("c2_valid", {31'b0, if_valid}, 32'h1);
        check("c2_pc", if_pc, 32'h0);
        check("c2_instr", if_instr, 32'h3408_0006);
        check("c2_pc4", if_pc_plus4, 32'h4);
        check("c2_addr", imem_addr, 32'h4);

        // Cycle 3: second instruction, then stall for three cycles
        next_cycle();
        id_stall = 1'b1;
        sample_point();
        check("c3_pc", if_pc, 32'h4);
        check("c3_instr", if_instr, 32'hAC08_0000);
        check("stall0_addr", imem_addr, 32'h4);
        for (int k = 1; k < 3; k++) begin
            next_cycle();
            sample_point();
            check("stall_pc", if_pc, 32'h4);
            check("stall_instr", if_instr, 32'hAC08_0000);
            check("stall_addr", imem_addr, 32'h4);
            check("stall_valid", {31'b0, if_valid}, 32'h1);
        end
        next_cycle();
        id_stall = 1'b0;
        sample_point();
        check("unstall_pc", if_pc, 32'h4);
        check("unstall_addr", imem_addr, 32'h8);
        next_cycle();
        sample_point();
        check("post_stall_pc", if_pc, 32'h8);
        check("post_stall_instr", if_instr, 32'hA000_0002);

        // Redirect to 0x10 at if_pc=8
        redirect_valid = 1'b1; redirect_target = 32'h10;
        #1;
        check("redir_addr", imem_addr, 32'h10);
        next_cycle();
        redirect_valid = 1'b0; redirect_target = 32'h0;
        sample_point();
        check("redir_pc", if_pc, 32'h10);
        check("redir_valid", {31'b0, if_valid}, 32'h1);
        check("redir_instr", if_instr, 32'hA000_0004);
        next_cycle();
        sample_point();
        check("redir_seq_pc", if_pc, 32'h14);
        check("redir_seq_instr", if_instr, 32'hA000_0005);

        // Redirect to 0x20 concurrent with stall: redirect wins
        id_stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
        #1;
        check("rs_addr", imem_addr, 32'h20);
        next_cycle();
        id_stall = 1'b0; redirect_valid = 1'b0;
        sample_point();
        check("rs_pc", if_pc, 32'h20);
        check("rs_valid", {31'b0, if_valid}, 32'h1);
        check("rs_instr", if_instr, 32'hA000_0008);

        // Misaligned redirect faults
        redirect_valid = 1'b1; redirect_target = 32'h06;
        #1;
        check("bad_addr", imem_addr, 32'h06);
        next_cycle();
        redirect_valid = 1'b0;
        sample_point();
        check("flt_set", {31'b0, fetch_fault}, 32'h1);
        check("flt_addr", fault_addr, 32'h06);
        check("flt_valid", {31'b0, if_valid}, 32'h0);
        check("flt_instr", if_instr, 32'h0);
        // Frozen regardless of stall/redirect activity
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            redirect_valid = (k % 2) == 0;
            redirect_target = 32'h40;
            id_stall = (k % 2) == 1;
            sample_point();
            check("frz_fault", {31'b0, fetch_fault}, 32'h1);
            check("frz_faddr", fault_addr, 32'h06);
            check("frz_pc", if_pc, 32'h20);
            check("frz_addr", imem_addr, 32'h20);
            check("frz_valid", {31'b0, if_valid}, 32'h0);
        end
        // Reset clears the fault, even with a redirect pending
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
        sample_point();
        check("clr_fault", {31'b0, fetch_fault}, 32'h0);
        check("clr_faddr", fault_addr, 32'h0);
        check("clr_pc", if_pc, 32'h0);
        check("clr_valid", {31'b0, if_valid}, 32'h0);
        check("clr_addr", imem_addr, 32'h0);
        next_cycle();
        sample_point();
        check("clr_refetch", if_instr, 32'h3408_0006);

        // Run-off from the top of memory
        reset_hi = 1'b1;
        next_cycle();
        reset_hi = 1'b0;
        sample_point();
        check("hi_c1_addr", imem_addr_hi, 32'hF8);
        check("hi_c1_valid", {31'b0, if_valid_hi}, 32'h0);
        next_cycle();
        sample_point();
        check("hi_c2_pc", if_pc_hi, 32'hF8);
        check("hi_c2_valid", {31'b0, if_valid_hi}, 32'h1);
        check("hi_c2_instr", if_instr_hi, 32'hA000_003E);
        next_cycle();
        sample_point();
        check("hi_c3_pc", if_pc_hi, 32'hFC);
        check("hi_c3_valid", {31'b0, if_valid_hi}, 32'h1);
        check("hi_c3_pc4", if_pc_plus4_hi, 32'h100);
        check("hi_c3_fault", {31'b0, fetch_fault_hi}, 32'h0);
        next_cycle();
        sample_point();
        check("hi_flt", {31'b0, fetch_fault_hi}, 32'h1);
        check("hi_faddr", fault_addr_hi, 32'h100);
        check("hi_valid", {31'b0, if_valid_hi}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the five-stage pipeline. It drives the word address into the synchronous-read instruction memory, which returns data one cycle after the address edge.
- It tracks which PC the returned word belongs to and presents instruction, PC, PC+4 and valid to decode.
- It absorbs decode stalls by re-fetching the held PC, and takes redirects (branch/jump) from later stages with zero bubble.
- Out-of-range or misaligned fetch addresses raise a sticky fault.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_WORDS, 64, instruction memory depth in words; legal byte addresses are 0 .. MEM_WORDS*4-4.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  byte address to instruction memory; memory uses addr[31:2]; combinational from state and redirect.
- imem_rdata  in  32  memory word for the address presented in the previous cycle.
- id_stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  branch/jump taken; overrides stall.
- redirect_target  in  32  new fetch byte address.
- if_instr  out  32  instruction to decode; 32'h0 (NOP) when not valid.
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4.
- if_valid  out  1  if_instr is a real, in-order instruction.
- fetch_fault  out  1  sticky; set on illegal fetch address.
- fault_addr  out  32  offending address, captured when the fault sets.

Behaviour:
- State registers:
  - F: next sequential fetch PC.
  - R_pc: PC whose data is on imem_rdata.
  - R_valid.
  - fault_q.
  - fault_addr_q.
- Reset values: F=RESET_PC, R_pc=RESET_PC, R_valid=0, fault_q=0, fault_addr_q=0.
- Output values during and immediately after reset: if_valid=0, if_instr=0, if_pc=RESET_PC, fetch_fault=0.
- Legal address: addr[1:0]==0 and addr < MEM_WORDS*4.
- Effective stall: hold = id_stall && R_valid. A bubble is never held.
- imem_addr priority:
  - fault_q → R_pc.
  - redirect_valid → redirect_target.
  - hold → R_pc (re-read keeps imem_rdata unchanged).
  - otherwise → F.
- Posedge update priority:
  1. reset → reset values.
  2. fault_q → freeze all state.
  3. redirect_valid:
     - target illegal → fault_q=1, fault_addr=target, R_valid=0.
     - target legal → R_pc=target, R_valid=1, F=target+4.
  4. hold → all state unchanged.
  5. else:
     - F illegal → fault_q=1, fault_addr=F, R_valid=0.
     - F legal → R_pc=F, R_valid=1, F=F+4.
- Output definitions: if_valid = R_valid && !fault_q; if_instr = if_valid ? imem_rdata : 0; if_pc = R_pc; if_pc_plus4 = R_pc+4 (32-bit wrap).
- Latency: first valid instruction in the cycle after reset deasserts plus one (address edge, then data). Sequential throughput is 1 instr/cycle.
- Redirect: a redirect asserted in cycle N makes the target instruction valid in cycle N+1. The word on the outputs in cycle N is still presented; squashing it is the redirecting stage's job.
- Simultaneous redirect and id_stall: redirect wins. The stalled word is discarded.
- Reset mid-stall or mid-redirect: reset wins; the next fetch is RESET_PC.
- Sequential run-off: PC reaching MEM_WORDS*4 faults. There is no wrap-around.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0.
  - Default RESET_PC.
  - Function addr_legal(addr, words).
- No sub-module. The next-PC and address selection is a small mux inside fetch_unit.

Test Plan:
- Memory preloaded word0=32'h34080006, word1=32'hAC080000. Release reset → imem_addr 0 in cycle 1; if_valid=1, if_pc=0, if_instr=32'h34080006 in cycle 2; if_pc=4, if_instr=32'hAC080000 in cycle 3.
- id_stall high 3 cycles while if_pc=4 → if_pc=4, if_instr=32'hAC080000, imem_addr=4 held throughout. Drop stall → if_pc=8 next cycle.
- redirect_valid with target 32'h10 at if_pc=8 → imem_addr=32'h10 that cycle; next cycle if_pc=32'h10, if_valid=1; following cycle if_pc=32'h14.
- redirect to 32'h20 while id_stall=1 → next cycle if_pc=32'h20, if_valid=1; the stalled word is dropped.
- redirect to 32'h06 → next cycle fetch_fault=1, fault_addr=32'h06, if_valid=0. State stays frozen for 5 cycles, then reset clears it.
- Free-run from RESET_PC=32'hF8 (MEM_WORDS=64) → if_pc 32'hF8, 32'hFC valid. Next cycle fetch_fault=1, fault_addr=32'h100, if_valid=0.
